mem_request_unit: RTL and testbench

//  Sequences instruction-fetch and data-memory requests between the decoded control signals
//  (memREN, memWEN, halt) and the cache interface (ihit/dhit handshake).

---
 rtl/mem_request_unit.sv | 130 +++++++++++++
 tb/tb_mem_request_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_unit.sv
// Sequences instruction fetch and data access requests against the I/D cache hit handshake,
// retiring each instruction with a one-cycle pc_en, plus a sticky halt and a watchdog timeout.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IFETCH | fetch request out, waiting for ihit
// S_DATA   | load/store request held stable, waiting for dhit
// S_HALTED | HALT retired, all requests idle until reset
// S_ERROR  | watchdog expired, all requests idle until reset
module mem_request_unit #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_ren_i,
    input  logic              mem_wen_i,
    input  logic              halt_i,
    input  logic [WORD_W-1:0] alu_addr_i,
    input  logic [WORD_W-1:0] store_data_i,
    input  logic              ihit_i,
    input  logic              dhit_i,
    input  logic [WORD_W-1:0] dload_i,
    output logic              imem_ren_o,
    output logic              dmem_ren_o,
    output logic              dmem_wen_o,
    output logic [WORD_W-1:0] dmem_addr_o,
    output logic [WORD_W-1:0] dmem_store_o,
    output logic [WORD_W-1:0] ld_data_o,
    output logic              ld_valid_o,
    output logic              pc_en_o,
    output logic              halted_o,
    output logic              timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IFETCH = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [1:0] S_ERROR  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, store_q, ld_data_q;
    logic              is_wr_q, ld_valid_q;
    logic              pc_en, latch, ld_capture, hit, waiting;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        pc_en      = 1'b0;
        latch      = 1'b0;
        ld_capture = 1'b0;
        hit        = 1'b0;
        waiting    = 1'b0;
        case (state_q)
            S_IFETCH: begin
                waiting = 1'b1;
                hit     = ihit_i;
                if (ihit_i) begin
                    if (halt_i) begin
                        state_d = S_HALTED;
                    end else if (mem_ren_i || mem_wen_i) begin
                        state_d = S_DATA;
                        latch   = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            S_DATA: begin
                waiting = 1'b1;
                hit     = dhit_i;
                if (dhit_i) begin
                    pc_en      = 1'b1;
                    ld_capture = ~is_wr_q;
                    state_d    = S_IFETCH;
                end
            end
            default: ;
        endcase

        // Count waiting cycles; the TIMEOUT-th one without a hit trips the watchdog.
        if (waiting && !hit) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d = S_ERROR;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IFETCH;
            cnt_q      <= '0;
            addr_q     <= '0;
            store_q    <= '0;
            is_wr_q    <= 1'b0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_valid_q <= ld_capture;
            if (latch) begin
                addr_q  <= alu_addr_i;
                store_q <= store_data_i;
                is_wr_q <= mem_wen_i;
            end
            if (ld_capture) begin
                ld_data_q <= dload_i;
            end
        end
    end

    // Store wins when both type bits are set, so read is only the absence of write.
    assign imem_ren_o   = (state_q == S_IFETCH);
    assign dmem_ren_o   = (state_q == S_DATA) && !is_wr_q;
    assign dmem_wen_o   = (state_q == S_DATA) && is_wr_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_store_o = store_q;
    assign ld_data_o    = ld_data_q;
    assign ld_valid_o   = ld_valid_q;
    assign pc_en_o      = pc_en;
    assign halted_o     = (state_q == S_HALTED);
    assign timeout_o    = (state_q == S_ERROR);

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit: fetch, load, store, halt, watchdog and async reset.
module tb_mem_request_unit;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_ren_i, mem_wen_i, halt_i, ihit_i, dhit_i;
    logic [31:0] alu_addr_i, store_data_i, dload_i;
    logic        imem_ren_o, dmem_ren_o, dmem_wen_o, ld_valid_o, pc_en_o, halted_o, timeout_o;
    logic [31:0] dmem_addr_o, dmem_store_o, ld_data_o;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_request_unit #(.WORD_W(32), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i),
        .halt_i(halt_i), .alu_addr_i(alu_addr_i), .store_data_i(store_data_i),
        .ihit_i(ihit_i), .dhit_i(dhit_i), .dload_i(dload_i), .imem_ren_o(imem_ren_o),
        .dmem_ren_o(dmem_ren_o), .dmem_wen_o(dmem_wen_o), .dmem_addr_o(dmem_addr_o),
        .dmem_store_o(dmem_store_o), .ld_data_o(ld_data_o), .ld_valid_o(ld_valid_o),
        .pc_en_o(pc_en_o), .halted_o(halted_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle_inputs();
        mem_ren_i = 0; mem_wen_i = 0; halt_i = 0; ihit_i = 0; dhit_i = 0;
        alu_addr_i = 0; store_data_i = 0; dload_i = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_i);
        n_checks++; if (imem_ren_o !== 1'b1) begin n_errors++; $display("FAIL rst_imem_ren: got %b expected 1", imem_ren_o); end
        n_checks++; if (dmem_ren_o !== 1'b0) begin n_errors++; $display("FAIL rst_dmem_ren: got %b expected 0", dmem_ren_o); end
        n_checks++; if (dmem_wen_o !== 1'b0) begin n_errors++; $display("FAIL rst_dmem_wen: got %b expected 0", dmem_wen_o); end
        n_checks++; if (pc_en_o !== 1'b0) begin n_errors++; $display("FAIL rst_pc_en: got %b expected 0", pc_en_o); end
        n_checks++; if (ld_data_o !== 32'h0) begin n_errors++; $display("FAIL rst_ld_data: got %h expected 0", ld_data_o); end
        n_checks++; if (dmem_addr_o !== 32'h0) begin n_errors++; $display("FAIL rst_dmem_addr: got %h expected 0", dmem_addr_o); end
        n_checks++; if (dmem_store_o !== 32'h0) begin n_errors++; $display("FAIL rst_dmem_store: got %h expected 0", dmem_store_o); end
        n_checks++; if ({ld_valid_o, halted_o, timeout_o} !== 3'b000) begin n_errors++; $display("FAIL rst_flags: got %b expected 000", {ld_valid_o, halted_o, timeout_o}); end
        next_cycle();
    endtask

    task automatic test_add();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ihit_i = 1;
            @(negedge clk_i);
            n_checks++; if (pc_en_o !== 1'b1) begin n_errors++; $display("FAIL add_pc_en[%0d]: got %b expected 1", i, pc_en_o); end
            n_checks++; if (imem_ren_o !== 1'b1) begin n_errors++; $display("FAIL add_imem_ren[%0d]: got %b expected 1", i, imem_ren_o); end
            next_cycle();
        end
        ihit_i = 0;
        @(negedge clk_i);
        n_checks++; if (pc_en_o !== 1'b0) begin n_errors++; $display("FAIL add_no_ihit_pc_en: got %b expected 0", pc_en_o); end
        next_cycle();
    endtask

    task automatic test_lw();
        do_reset();
        ihit_i = 1; mem_ren_i = 1; alu_addr_i = 32'h100;
        @(negedge clk_i);
        n_checks++; if (pc_en_o !== 1'b0) begin n_errors++; $display("FAIL lw_issue_pc_en: got %b expected 0", pc_en_o); end
        next_cycle();
        ihit_i = 0; mem_ren_i = 0; alu_addr_i = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_checks++; if ({imem_ren_o, dmem_ren_o, dmem_wen_o, pc_en_o} !== 4'b0100) begin n_errors++; $display("FAIL lw_wait_ctrl[%0d]: got %b expected 0100", i, {imem_ren_o, dmem_ren_o, dmem_wen_o, pc_en_o}); end
            n_checks++; if (dmem_addr_o !== 32'h100) begin n_errors++; $display("FAIL lw_wait_addr[%0d]: got %h expected 00000100", i, dmem_addr_o); end
            next_cycle();
        end
        dhit_i = 1; dload_i = 32'hDEADBEEF;
        @(negedge clk_i);
        n_checks++; if ({dmem_ren_o, pc_en_o} !== 2'b11) begin n_errors++; $display("FAIL lw_dhit_ctrl: got %b expected 11", {dmem_ren_o, pc_en_o}); end
        next_cycle();
        dhit_i = 0; dload_i = 32'h0;
        @(negedge clk_i);
        n_checks++; if (ld_valid_o !== 1'b1) begin n_errors++; $display("FAIL lw_ld_valid: got %b expected 1", ld_valid_o); end
        n_checks++; if (ld_data_o !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lw_ld_data: got %h expected deadbeef", ld_data_o); end
        n_checks++; if ({imem_ren_o, pc_en_o} !== 2'b10) begin n_errors++; $display("FAIL lw_return_ctrl: got %b expected 10", {imem_ren_o, pc_en_o}); end
        next_cycle();
        @(negedge clk_i);
        n_checks++; if (ld_valid_o !== 1'b0) begin n_errors++; $display("FAIL lw_ld_valid_pulse: got %b expected 0", ld_valid_o); end
        next_cycle();
    endtask

    task automatic test_sw();
        // ld_data carries 0xDEADBEEF from the preceding load test; the store must not disturb it.
        ihit_i = 1; mem_wen_i = 1; store_data_i = 32'h5A5A5A5A; alu_addr_i = 32'h44;
        next_cycle();
        ihit_i = 0; mem_wen_i = 0; store_data_i = 0; alu_addr_i = 0;
        dhit_i = 1; dload_i = 32'h12345678;
        @(negedge clk_i);
        n_checks++; if ({dmem_wen_o, dmem_ren_o, pc_en_o} !== 3'b101) begin n_errors++; $display("FAIL sw_ctrl: got %b expected 101", {dmem_wen_o, dmem_ren_o, pc_en_o}); end
        n_checks++; if (dmem_store_o !== 32'h5A5A5A5A) begin n_errors++; $display("FAIL sw_store: got %h expected 5a5a5a5a", dmem_store_o); end
        n_checks++; if (dmem_addr_o !== 32'h44) begin n_errors++; $display("FAIL sw_addr: got %h expected 00000044", dmem_addr_o); end
        next_cycle();
        dhit_i = 0;
        @(negedge clk_i);
        n_checks++; if ({pc_en_o, ld_valid_o} !== 2'b00) begin n_errors++; $display("FAIL sw_after: got %b expected 00", {pc_en_o, ld_valid_o}); end
        n_checks++; if (ld_data_o !== 32'hDEADBEEF) begin n_errors++; $display("FAIL sw_ld_data_kept: got %h expected deadbeef", ld_data_o); end
        next_cycle();
    endtask

    task automatic test_both_is_store();
        do_reset();
        ihit_i = 1; mem_ren_i = 1; mem_wen_i = 1; alu_addr_i = 32'h80; store_data_i = 32'hCAFE0001;
        next_cycle();
        ihit_i = 0; mem_ren_i = 0; mem_wen_i = 0;
        @(negedge clk_i);
        n_checks++; if ({dmem_wen_o, dmem_ren_o} !== 2'b10) begin n_errors++; $display("FAIL both_type: got %b expected 10", {dmem_wen_o, dmem_ren_o}); end
        next_cycle();
        dhit_i = 1; dload_i = 32'h77777777;
        next_cycle();
        dhit_i = 0;
        @(negedge clk_i);
        n_checks++; if ({ld_valid_o, ld_data_o} !== {1'b0, 32'h0}) begin n_errors++; $display("FAIL both_no_load: got %b/%h expected 0/00000000", ld_valid_o, ld_data_o); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        ihit_i = 1; mem_ren_i = 1; alu_addr_i = 32'h200;
        next_cycle();
        mem_ren_i = 0; dhit_i = 1; dload_i = 32'h0BADF00D;
        @(negedge clk_i);
        n_checks++; if ({pc_en_o, imem_ren_o} !== 2'b10) begin n_errors++; $display("FAIL b2b_dhit: got %b expected 10", {pc_en_o, imem_ren_o}); end
        next_cycle();
        dhit_i = 0;
        @(negedge clk_i);
        n_checks++; if ({pc_en_o, imem_ren_o, ld_valid_o} !== 3'b111) begin n_errors++; $display("FAIL b2b_ifetch: got %b expected 111", {pc_en_o, imem_ren_o, ld_valid_o}); end
        next_cycle();
        ihit_i = 0;
    endtask

    task automatic test_halt();
        do_reset();
        ihit_i = 1; halt_i = 1; mem_ren_i = 1;
        @(negedge clk_i);
        n_checks++; if (pc_en_o !== 1'b0) begin n_errors++; $display("FAIL halt_issue_pc_en: got %b expected 0", pc_en_o); end
        next_cycle();
        halt_i = 0;
        for (int i = 0; i < 3; i++) begin
            ihit_i = 1; dhit_i = 1; mem_wen_i = (i == 1);
            @(negedge clk_i);
            n_checks++; if ({halted_o, pc_en_o, imem_ren_o, dmem_ren_o, dmem_wen_o} !== 5'b10000) begin n_errors++; $display("FAIL halt_hold[%0d]: got %b expected 10000", i, {halted_o, pc_en_o, imem_ren_o, dmem_ren_o, dmem_wen_o}); end
            next_cycle();
        end
        do_reset();
        @(negedge clk_i);
        n_checks++; if ({halted_o, imem_ren_o} !== 2'b01) begin n_errors++; $display("FAIL halt_cleared: got %b expected 01", {halted_o, imem_ren_o}); end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        ihit_i = 1; mem_ren_i = 1; alu_addr_i = 32'h300;
        next_cycle();
        ihit_i = 0; mem_ren_i = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            n_checks++; if ({timeout_o, dmem_ren_o} !== 2'b01) begin n_errors++; $display("FAIL to_wait[%0d]: got %b expected 01", i, {timeout_o, dmem_ren_o}); end
            next_cycle();
        end
        @(negedge clk_i);
        n_checks++; if ({timeout_o, dmem_ren_o, imem_ren_o, pc_en_o} !== 4'b1000) begin n_errors++; $display("FAIL to_expired: got %b expected 1000", {timeout_o, dmem_ren_o, imem_ren_o, pc_en_o}); end
        next_cycle();
        dhit_i = 1; ihit_i = 1;
        @(negedge clk_i);
        n_checks++; if ({timeout_o, pc_en_o} !== 2'b10) begin n_errors++; $display("FAIL to_sticky: got %b expected 10", {timeout_o, pc_en_o}); end
        next_cycle();

        do_reset();
        ihit_i = 1; mem_ren_i = 1;
        next_cycle();
        ihit_i = 0; mem_ren_i = 0;
        repeat (7) next_cycle();
        dhit_i = 1; dload_i = 32'h00C0FFEE;
        @(negedge clk_i);
        n_checks++; if ({pc_en_o, timeout_o} !== 2'b10) begin n_errors++; $display("FAIL to_last_hit: got %b expected 10", {pc_en_o, timeout_o}); end
        next_cycle();
        dhit_i = 0;
        @(negedge clk_i);
        n_checks++; if ({timeout_o, imem_ren_o, ld_data_o} !== {2'b01, 32'h00C0FFEE}) begin n_errors++; $display("FAIL to_no_error: got %b/%b/%h expected 0/1/00c0ffee", timeout_o, imem_ren_o, ld_data_o); end
        next_cycle();
    endtask

    task automatic test_ifetch_timeout();
        do_reset();
        repeat (7) next_cycle();
        @(negedge clk_i);
        n_checks++; if (timeout_o !== 1'b0) begin n_errors++; $display("FAIL ifto_early: got %b expected 0", timeout_o); end
        next_cycle();
        @(negedge clk_i);
        n_checks++; if ({timeout_o, imem_ren_o} !== 2'b10) begin n_errors++; $display("FAIL ifto_expired: got %b expected 10", {timeout_o, imem_ren_o}); end
        next_cycle();
    endtask

    task automatic test_reset_in_data();
        do_reset();
        ihit_i = 1; mem_ren_i = 1; alu_addr_i = 32'h10;
        next_cycle();
        ihit_i = 0; mem_ren_i = 0; dhit_i = 1; dload_i = 32'hA5A5A5A5;
        next_cycle();
        dhit_i = 0;
        ihit_i = 1; mem_ren_i = 1; alu_addr_i = 32'h20;
        next_cycle();
        ihit_i = 0; mem_ren_i = 0;
        next_cycle();
        @(negedge clk_i);
        n_checks++; if ({dmem_ren_o, ld_data_o} !== {1'b1, 32'hA5A5A5A5}) begin n_errors++; $display("FAIL rdata_pre: got %b/%h expected 1/a5a5a5a5", dmem_ren_o, ld_data_o); end
        next_cycle();
        rst_i = 1;
        #1;
        n_checks++; if (dmem_ren_o !== 1'b0) begin n_errors++; $display("FAIL rdata_async_drop: got %b expected 0", dmem_ren_o); end
        @(posedge clk_i); #1 rst_i = 0;
        @(negedge clk_i);
        n_checks++; if ({imem_ren_o, dmem_ren_o, ld_data_o, dmem_addr_o} !== {2'b10, 32'h0, 32'h0}) begin n_errors++; $display("FAIL rdata_after: got %b%b/%h/%h expected 10/00000000/00000000", imem_ren_o, dmem_ren_o, ld_data_o, dmem_addr_o); end
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        rst_i = 1;
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_both_is_store();
        test_back_to_back();
        test_halt();
        test_timeout();
        test_ifetch_timeout();
        test_reset_in_data();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
